barrel_rshifter_pipe: RTL and testbench
=======================================

BARREL_RSHIFTER_PIPE -- requirements
Module: barrel_rshifter_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the data word width in bits (minimum 2).
REQ-002 SHALL have parameter SHIFT_WIDTH, default $clog2(DATA_WIDTH) if DATA_WIDTH is a power of 2, else $clog2(DATA_WIDTH)+1, giving the rotate-amount width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an input beat is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the offered beat.
REQ-007 SHALL have port data_in, input, DATA_WIDTH bits: word to rotate.
REQ-008 SHALL have port shift_val_in, input, SHIFT_WIDTH bits: right-rotate amount.
REQ-009 SHALL have port out_valid, output, 1 bit: a result beat is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream accepts the result beat.
REQ-011 SHALL have port data_out, output, DATA_WIDTH bits: the rotated word.
REQ-012 SHALL have port err_out, output, 1 bit: shift_val_in was >= DATA_WIDTH for this beat.

Function
REQ-013 SHALL transfer an input beat on a cycle with in_valid=1 and in_ready=1, and an output beat on a cycle with out_valid=1 and out_ready=1.
REQ-014 SHALL compute data_out = data_in rotated right by shift_val_in; this is the exact inverse of the team's left barrel rotator for amounts 0..DATA_WIDTH-1.
REQ-015 SHALL implement SHIFT_WIDTH register stages; stage k rotates right by 2^k when shift bit k is 1 and passes the word unchanged otherwise, processing bits in order LSB first.
REQ-016 SHALL give each stage its own valid bit, data register, remaining shift bits and err bit; the last stage drives out_valid, data_out and err_out directly from registers.
REQ-017 SHALL have a latency of exactly SHIFT_WIDTH cycles from the input transfer to out_valid when there is no back-pressure.
REQ-018 SHALL sustain one beat per cycle when out_ready is held at 1.
REQ-019 SHALL load stage k when stage k is empty or stage k advances; stage k advances when it is valid and stage k+1 loads (for the last stage, when out_ready=1).
REQ-020 SHALL drive in_ready = ~rst & (~stage0_valid | stage0_advances), combinationally from out_ready through the stage chain; there is no skid buffer.
REQ-021 SHALL hold data_out and err_out stable while out_valid=1 and out_ready=0; no beat SHALL be dropped or duplicated.
REQ-022 SHALL, when shift_val_in >= DATA_WIDTH (possible only for non-power-of-2 widths), set err_out=1 and force data_out=0 for that beat, with the same latency and handshake as a normal beat.
REQ-023 SHALL pass shift_val_in=0 through unchanged, with err_out=0.
REQ-024 SHALL ignore data_in and shift_val_in on any cycle with no input transfer; a stage that is not loading SHALL hold its contents.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear every stage valid, data and err register to 0, giving out_valid=0, data_out=0 and err_out=0.
REQ-026 SHALL hold in_ready=0 while rst=1 and discard any beats in flight; in_ready may first be 1 in the cycle after rst deasserts.

Structure
REQ-027 SHALL take the SHIFT_WIDTH derivation function from a shared package barrel_shifter_pkg, which is also used by the left rotator.
REQ-028 SHALL build each stage from one sub-module, barrel_rshifter_stage (parameters DATA_WIDTH, SHIFT_WIDTH, STAGE_IDX), instantiated SHIFT_WIDTH times with generate.
REQ-029 SHALL keep the total RTL for the block, including the stage sub-module, within 120-400 lines.

Verification
REQ-030 W=8: data_in=0x99, shift=3, out_ready=1 -> data_out=0x33, err_out=0, exactly 3 cycles after the transfer.
REQ-031 W=8 round trip: left-rotator(0x99,3)=0xCC fed in with shift=3 -> data_out=0x99; sweep all 256 words x 8 amounts against a reference model.
REQ-032 W=8: 8 back-to-back beats with out_ready=0 for cycles 4-9 -> in_ready drops once all 3 stages are full, all 8 outputs arrive in order and correct, data_out is stable during the stall.
REQ-033 W=6: shift=6 and shift=7 -> err_out=1, data_out=0; shift=5 with data_in=0x21 -> data_out=0x03, err_out=0.
REQ-034 W=8: rst=1 for 1 cycle while 2 beats are in flight -> out_valid=0 the next cycle, no stale beat appears, in_ready=1 after deassert.
REQ-035 Random in_valid/out_ready (50%) over 10k beats -> scoreboard shows no loss, duplication or reordering.

Source files
------------

// File: rtl/barrel_shifter_pkg.sv
// barrel_shifter_pkg: helpers shared by the left and right barrel rotators.
// Contents:
//   shift_width(w) - width of the rotate-amount field for a w-bit word
package barrel_shifter_pkg;

    // Power-of-2 widths need exactly log2(w) bits. Other widths get one extra
    // bit, so amounts >= w can be expressed and flagged as errors.
    function automatic int shift_width(input int w);
        return ((w & (w - 1)) == 0) ? $clog2(w) : $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/barrel_rshifter_stage.sv
// barrel_rshifter_stage: one register stage of the right-rotate pipeline.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   valid_in     - upstream holds a beat
//   data_in      - upstream word
//   shift_in     - upstream rotate amount
//   err_in       - upstream error flag
//   next_load    - downstream loads this cycle (out_ready for the last stage)
//   load         - this stage loads this cycle (ready seen by upstream)
//   valid        - registered beat valid
//   data         - registered word
//   shift        - registered rotate amount
//   err          - registered error flag
module barrel_rshifter_stage
    import barrel_shifter_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = shift_width(DATA_WIDTH),
    parameter int STAGE_IDX   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [SHIFT_WIDTH-1:0] shift_in,
    input  logic                   err_in,
    input  logic                   next_load,
    output logic                   load,
    output logic                   valid,
    output logic [DATA_WIDTH-1:0]  data,
    output logic [SHIFT_WIDTH-1:0] shift,
    output logic                   err
);

    // Stages whose weight reaches past the word width only fire on error
    // beats, whose data is already zero, so reducing the amount modulo the
    // width keeps the shifts in range.
    localparam int AMT = (1 << STAGE_IDX) % DATA_WIDTH;

    logic [DATA_WIDTH-1:0] rotated;

    assign rotated = err_in ? '0 :
                     shift_in[STAGE_IDX] ? ((data_in >> AMT) | (data_in << (DATA_WIDTH - AMT))) :
                     data_in;

    // An empty stage always loads. A full stage loads only when it can hand
    // its beat downstream this cycle.
    assign load = ~valid | next_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            shift <= '0;
            err   <= 1'b0;
        end else if (load) begin
            valid <= valid_in;
            if (valid_in) begin
                data  <= rotated;
                shift <= shift_in;
                err   <= err_in;
            end
        end
    end

endmodule

// File: rtl/barrel_rshifter_pipe.sv
// barrel_rshifter_pipe: pipelined right barrel rotator with a valid/ready handshake.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   in_valid      - input beat offered
//   in_ready      - input beat accepted
//   data_in       - word to rotate
//   shift_val_in  - right-rotate amount
//   out_valid     - result beat presented
//   out_ready     - downstream accepts the result beat
//   data_out      - rotated word (zero on error)
//   err_out       - rotate amount was >= DATA_WIDTH
module barrel_rshifter_pipe
    import barrel_shifter_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = shift_width(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [SHIFT_WIDTH-1:0] shift_val_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   err_out
);

    // Entry k of each chain feeds stage k. Entry SHIFT_WIDTH is the last stage's output.
    logic                   valid_c [SHIFT_WIDTH+1];
    logic [DATA_WIDTH-1:0]  data_c  [SHIFT_WIDTH+1];
    logic [SHIFT_WIDTH-1:0] shift_c [SHIFT_WIDTH+1];
    logic                   err_c   [SHIFT_WIDTH+1];
    logic                   load_c  [SHIFT_WIDTH+1];

    assign valid_c[0] = in_valid;
    assign data_c[0]  = data_in;
    assign shift_c[0] = shift_val_in;
    assign err_c[0]   = {1'b0, shift_val_in} >= (SHIFT_WIDTH + 1)'(DATA_WIDTH);
    assign load_c[SHIFT_WIDTH] = out_ready;

    for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
        barrel_rshifter_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .SHIFT_WIDTH(SHIFT_WIDTH),
            .STAGE_IDX  (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .valid_in (valid_c[k]),
            .data_in  (data_c[k]),
            .shift_in (shift_c[k]),
            .err_in   (err_c[k]),
            .next_load(load_c[k+1]),
            .load     (load_c[k]),
            .valid    (valid_c[k+1]),
            .data     (data_c[k+1]),
            .shift    (shift_c[k+1]),
            .err      (err_c[k+1])
        );
    end

    assign in_ready  = ~rst & load_c[0];
    assign out_valid = valid_c[SHIFT_WIDTH];
    assign data_out  = data_c[SHIFT_WIDTH];
    assign err_out   = err_c[SHIFT_WIDTH];

endmodule

// File: tb/tb_barrel_rshifter_pipe.sv
// tb_barrel_rshifter_pipe: directed and scoreboarded checks of the right-rotate pipeline (W=8 and W=6).
module tb_barrel_rshifter_pipe;

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic [7:0] e;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, err_out;
    logic [7:0] data_in, data_out;
    logic [2:0] shift_in;
    logic       iv6, ir6, ov6, or6, err6;
    logic [5:0] d6, q6;
    logic [3:0] s6;

    int    checks = 0;
    int    errors = 0;
    beat_t src[$];
    beat_t exp_q[$];

    always #5 clk = ~clk;

    barrel_rshifter_pipe #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .shift_val_in(shift_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .err_out(err_out)
    );

    barrel_rshifter_pipe #(.DATA_WIDTH(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6),
        .data_in(d6), .shift_val_in(s6), .out_valid(ov6),
        .out_ready(or6), .data_out(q6), .err_out(err6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ror8(input logic [7:0] d, input int s);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[(i + s) % 8];
        return r;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] d, input int s);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[(i + s) % 8] = d[i];
        return r;
    endfunction

    // Push src through dut8 with random valid/ready percentages; out_ready is
    // forced low for cycles stall_lo..stall_hi (counting from 1).
    task automatic stream8(input string tag, input int pin, input int pout, input int stall_lo, input int stall_hi);
        int         cyc = 1;
        bit         fin, fout, held = 0;
        logic [8:0] hv = '0;
        beat_t      b;
        while ((src.size() > 0 || exp_q.size() > 0) && cyc < 60000) begin
            in_valid = (src.size() > 0) && ($urandom_range(99) < pin);
            if (in_valid) begin
                data_in  = src[0].d;
                shift_in = src[0].s;
            end
            out_ready = (cyc >= stall_lo && cyc <= stall_hi) ? 1'b0 : ($urandom_range(99) < pout);
            #1;
            if (cyc == stall_lo) chk({tag, "_stall_in_ready"}, in_ready, 0);
            if (held) chk({tag, "_hold"}, {out_valid, err_out, data_out}, {1'b1, hv});
            held = out_valid && !out_ready;
            hv   = {err_out, data_out};
            fin  = in_valid && in_ready;
            fout = out_valid && out_ready;
            if (fout) begin
                if (exp_q.size() == 0) chk({tag, "_spurious"}, 1, 0);
                else begin
                    b = exp_q.pop_front();
                    chk({tag, "_data"}, {err_out, data_out}, {1'b0, b.e});
                end
            end
            if (fin) exp_q.push_back(src.pop_front());
            tick();
            cyc++;
        end
        chk({tag, "_drain"}, src.size() + exp_q.size(), 0);
        src.delete();
        exp_q.delete();
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic one6(input logic [5:0] d, input logic [3:0] s, input logic [5:0] ed, input logic ee);
        iv6 = 1'b1;
        d6  = d;
        s6  = s;
        #1;
        chk("w6_in_ready", ir6, 1);
        tick();
        iv6 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk("w6_latency", ov6, c == 4);
            if (c == 4) chk("w6_result", {err6, q6}, {ee, ed});
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data_in = '0; shift_in = '0;
        iv6 = 1'b0; or6 = 1'b1; d6 = '0; s6 = '0;
        #1;
        tick();
        tick();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_err_out", err_out, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_w6_out", {ov6, err6, q6}, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);
        tick();

        // 0x99 ror 3 = 0x33, visible 3 cycles after the transfer
        in_valid = 1'b1; data_in = 8'h99; shift_in = 3'd3;
        #1;
        chk("lat_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("lat_out_valid", out_valid, c == 3);
            if (c == 3) chk("lat_result", {err_out, data_out}, {1'b0, 8'h33});
            tick();
        end

        src.push_back('{8'hCC, 3'd3, 8'h99});
        stream8("round_trip", 100, 100, 0, 0);

        for (int d = 0; d < 256; d++)
            for (int s = 0; s < 8; s++) begin
                src.push_back('{8'(d), 3'(s), ror8(8'(d), s)});
                src.push_back('{rol8(8'(d), s), 3'(s), 8'(d)});
            end
        stream8("sweep", 100, 100, 0, 0);

        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            logic [2:0] s;
            d = 8'($urandom);
            s = 3'($urandom);
            src.push_back('{d, s, ror8(d, s)});
        end
        stream8("stall", 100, 100, 4, 9);

        // reset with two beats in flight
        in_valid = 1'b1; out_ready = 1'b1; data_in = 8'h0F; shift_in = 3'd1;
        tick();
        data_in = 8'hF0; shift_in = 3'd2;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("flight_rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("flight_out", {out_valid, err_out, data_out}, 0);
        chk("flight_in_ready", in_ready, 1);
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("flight_no_stale", out_valid, 0);
            tick();
        end

        one6(6'h3F, 4'd6, 6'h00, 1'b1);
        one6(6'h15, 4'd7, 6'h00, 1'b1);
        one6(6'h21, 4'd5, 6'h03, 1'b0);
        one6(6'h2A, 4'd0, 6'h2A, 1'b0);
        one6(6'h01, 4'd1, 6'h20, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            logic [7:0] d;
            logic [2:0] s;
            d = 8'($urandom);
            s = 3'($urandom);
            src.push_back('{d, s, ror8(d, s)});
        end
        stream8("random", 50, 50, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
